// File: rtl/simon_pkg.sv
// Shared types for the Simon Says sequencer: FSM states, colour encoding and
// the LFSR feedback tap mask.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE, APPEND, FETCH, LOAD, SHOW, GAP, IN_FETCH, IN_LOAD, WAIT_IN, WIN, LOSE
  } state_t;

  typedef enum logic [1:0] {
    RED, GREEN, BLUE, YELLOW
  } color_t;

  // Taps 8,6,5,4 of a maximal-length 8-bit Fibonacci LFSR (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR. Exposes the low two bits of the value
// being loaded on the coming edge, so a register fed by it matches lfsr_q.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] nxt_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  assign nxt_o  = lfsr_d[1:0];

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: grows the sequence, plays it back, checks presses.
// Define SIMON_TIMEOUT_EN to make player inactivity in WAIT_IN a loss.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int         DEPTH          = 16,
  parameter int         AW             = 4,
  parameter int         ON_CYCLES      = 25_000_000,
  parameter int         OFF_CYCLES     = 12_000_000,
  parameter int         TIMEOUT_CYCLES = 150_000_000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          btn_valid,
  input  logic [1:0]    btn_color,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  output logic          led_on,
  output logic [1:0]    led_color,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          awaiting_input,
  output logic          win,
  output logic          lose
);

  localparam int CMAX1 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CMAX  = (CMAX1 > TIMEOUT_CYCLES) ? CMAX1 : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  color_t        cur_q, cur_d;
  logic [1:0]    rnd;
  logic          last;

  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [1:0]    mem_wdata_q;
  logic          led_on_q;
  logic [1:0]    led_color_q;
  logic          busy_q;
  logic          awaiting_q;
  logic          win_q;
  logic          lose_q;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .nxt_o(rnd)
  );

  assign last = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          state_d = APPEND;
        end
      end
      APPEND: begin
        len_d   = len_q + 1'b1;
        idx_d   = '0;
        state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        cur_d   = color_t'(mem_rdata);
        state_d = SHOW;
      end
      SHOW: if (cnt_q == ON_LAST) state_d = GAP;
      GAP: begin
        if (cnt_q == OFF_LAST) begin
          if (last) begin
            idx_d   = '0;
            state_d = IN_FETCH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      IN_FETCH: state_d = IN_LOAD;
      IN_LOAD: begin
        cur_d   = color_t'(mem_rdata);
        state_d = WAIT_IN;
      end
      WAIT_IN: begin
        // A press on the final allowed cycle takes priority over the timeout.
        if (btn_valid) begin
          if (btn_color != cur_q) begin
            state_d = LOSE;
          end else if (!last) begin
            idx_d   = idx_q + 1'b1;
            state_d = IN_FETCH;
          end else if (len_q == LEN_MAX) begin
            state_d = WIN;
          end else begin
            state_d = APPEND;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = LOSE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      led_on_q    <= 1'b0;
      led_color_q <= '0;
      busy_q      <= 1'b0;
      awaiting_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= (state_d == APPEND);
      mem_addr_q  <= (state_d == APPEND) ? len_d[AW-1:0] :
                     ((state_d == FETCH) || (state_d == IN_FETCH)) ? idx_d : '0;
      mem_wdata_q <= (state_d == APPEND) ? rnd : '0;
      led_on_q    <= (state_d == SHOW);
      led_color_q <= (state_d == SHOW) ? cur_d : '0;
      busy_q      <= !((state_d == IDLE) || (state_d == WIN) || (state_d == LOSE));
      awaiting_q  <= (state_d == WAIT_IN);
      win_q       <= (state_d == WIN);
      lose_q      <= (state_d == LOSE);
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  assign mem_addr       = mem_addr_q;
  assign mem_we         = mem_we_q;
  assign mem_wdata      = mem_wdata_q;
  assign led_on         = led_on_q;
  assign led_color      = led_color_q;
  assign level          = len_q;
  assign busy           = busy_q;
  assign awaiting_input = awaiting_q;
  assign win            = win_q;
  assign lose           = lose_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl with a small game (DEPTH=4, ON=4, OFF=2, TIMEOUT=10)
// and a behavioural sync-read sequence RAM.
module tb_simon_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int ON    = 4;
  localparam int OFF   = 2;
  localparam int TO    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          btn_valid;
  logic [1:0]    btn_color;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;
  logic          led_on;
  logic [1:0]    led_color;
  logic [AW:0]   level;
  logic          busy;
  logic          awaiting_input;
  logic          win;
  logic          lose;

  logic [1:0] ram [DEPTH];
  logic [7:0] mlfsr;
  logic [1:0] seq [DEPTH];
  logic [1:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  simon_seq_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .ON_CYCLES(ON), .OFF_CYCLES(OFF),
    .TIMEOUT_CYCLES(TO), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid),
    .btn_color(btn_color), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .led_on(led_on),
    .led_color(led_color), .level(level), .busy(busy),
    .awaiting_input(awaiting_input), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, stepping every cycle.
  always @(posedge clk) begin
    if (reset) mlfsr <= 8'hA5;
    else       mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c, input bit with_start);
    btn_valid = 1'b1;
    btn_color = c;
    start     = with_start;
    tick;
    btn_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_await(output int k);
    k = 0;
    while (!awaiting_input && k < 20) begin
      k++;
      tick;
    end
    check("await_reach", awaiting_input, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_led"}, led_on, 0);
    check({tag, "_ledc"}, led_color, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_await"}, awaiting_input, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
  endtask

  // Entered at the negedge showing APPEND; returns at the first WAIT_IN cycle.
  task automatic run_round(input int n, input bit inject);
    logic [1:0] expc;
    int lo;
    int hi;
    check("append_we", mem_we, 1);
    check("append_addr", mem_addr, n - 1);
    check("append_wdata", mem_wdata, mlfsr[1:0]);
    check("append_busy", busy, 1);
    seq[n-1] = mlfsr[1:0];
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    tick;
    check("level_after_append", level, n);
    for (int i = 0; i < n; i++) begin
      lo = 0;
      hi = 0;
      while (!led_on && lo < 20) begin
        lo++;
        tick;
      end
      check((i == 0) ? "show_latency" : "gap_len", lo, (i == 0) ? 2 : OFF + 2);
      expc = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      check("show_color", led_color, expc);
      if (inject && i == 0) begin
        btn_valid = 1'b1;
        btn_color = ~expc;
        start     = 1'b1;
      end
      while (led_on && hi < 20) begin
        hi++;
        tick;
        btn_valid = 1'b0;
        start     = 1'b0;
      end
      check("on_len", hi, ON);
    end
    wait_await(lo);
    check("await_latency", lo, OFF + 2);
    check("level_wait", level, n);
  endtask

  task automatic answer_round(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      wait_await(k);
      if (i > 0) check("refetch_latency", k, 2);
      press(seq[i], (n == 2 && i == 1));
      if (i < n - 1) begin
        check("in_fetch_await", awaiting_input, 0);
        check("in_fetch_busy", busy, 1);
      end
    end
    if (n == DEPTH) begin
      check("win_flag", win, 1);
      check("win_busy", busy, 0);
      check("win_no_append", mem_we, 0);
    end
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_color = 2'b00;
    repeat (3) tick;
    check_all_zero("reset");
    reset = 1'b0;
    tick;
    check("idle_busy", busy, 0);

    // Full game won in four rounds.
    do_start;
    for (int n = 1; n <= DEPTH; n++) begin
      run_round(n, 1'b0);
      answer_round(n);
    end
    repeat (3) tick;
    check("win_held", win, 1);
    check("win_we_low", mem_we, 0);
    check("win_led_low", led_on, 0);

    // Restart from WIN, then lose on a wrong colour.
    do_start;
    check("restart_win_clr", win, 0);
    check("restart_lose_clr", lose, 0);
    run_round(1, 1'b0);
    press(seq[0] ^ 2'b01, 1'b0);
    check("lose_flag", lose, 1);
    check("lose_busy", busy, 0);
    check("lose_await", awaiting_input, 0);
    repeat (3) tick;
    check("lose_held", lose, 1);

    // Presses and start during SHOW are ignored; reset mid-SHOW clears all.
    do_start;
    check("restart_lose_clr2", lose, 0);
    run_round(1, 1'b1);
    answer_round(1);
    check("round2_append", mem_we, 1);
    k = 0;
    while (!led_on && k < 20) begin
      k++;
      tick;
    end
    check("round2_show", led_on, 1);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_all_zero("mid_reset");
    tick;
    do_start;
    run_round(1, 1'b0);

`ifdef SIMON_TIMEOUT_EN
    do_start;
    run_round(1, 1'b0);
    k = 0;
    while (awaiting_input && k < 30) begin
      k++;
      tick;
    end
    check("timeout_len", k, TO);
    check("timeout_lose", lose, 1);
    do_start;
    run_round(1, 1'b0);
    repeat (TO - 1) tick;
    check("last_cycle_await", awaiting_input, 1);
    press(seq[0], 1'b0);
    check("last_cycle_accept", mem_we, 1);
    check("last_cycle_nolose", lose, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
